// File: rtl/ex_div.sv
// Multi-cycle 32-bit divider for the EX stage: signed/unsigned quotient and remainder
// using one restoring shift-subtract iteration per clock.
module ex_div #(
    parameter logic [7:0] DIV_OP  = 8'h60,
    parameter logic [7:0] DIVU_OP = 8'h61,
    parameter logic [7:0] REM_OP  = 8'h62,
    parameter logic [7:0] REMU_OP = 8'h63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ex_aluop,
    input  logic [31:0] ex_reg1,
    input  logic [31:0] ex_reg2,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic        flush,
    output logic        stallreq,
    output logic        div_done,
    output logic [31:0] div_wdata,
    output logic [4:0]  div_wd,
    output logic        div_wreg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [7:0]  op;
    logic [4:0]  wd_cap;
    logic        wreg_cap;
    logic [31:0] divisor;
    logic        sign_a;
    logic        sign_b;
    logic [63:0] work;
    logic [4:0]  cnt;

    logic        is_op;
    logic        start;
    logic        in_signed;
    logic        in_rem;
    logic        zero_div;
    logic [31:0] a_abs;
    logic [31:0] b_abs;

    logic [32:0] partial;
    logic [32:0] diff;
    logic        borrow;
    logic [63:0] work_next;
    logic        cap_signed;
    logic        cap_rem;
    logic [31:0] q_fix;
    logic [31:0] r_fix;
    logic [31:0] result;

    // Decode the incoming operation and prepare start-time operands
    always_comb begin
        is_op     = (ex_aluop == DIV_OP) || (ex_aluop == DIVU_OP) ||
                    (ex_aluop == REM_OP) || (ex_aluop == REMU_OP);
        in_signed = (ex_aluop == DIV_OP) || (ex_aluop == REM_OP);
        in_rem    = (ex_aluop == REM_OP) || (ex_aluop == REMU_OP);
        start     = (state == IDLE) && is_op && !flush;
        zero_div  = (ex_reg2 == 32'h0);
        a_abs     = (in_signed && ex_reg1[31]) ? (32'h0 - ex_reg1) : ex_reg1;
        b_abs     = (in_signed && ex_reg2[31]) ? (32'h0 - ex_reg2) : ex_reg2;
        stallreq  = !rst && (start || (state == BUSY));
    end

    // One restoring iteration; a set partial[32] can never borrow since the divisor fits in 32 bits
    always_comb begin
        partial    = work[63:31];
        diff       = partial - {1'b0, divisor};
        borrow     = !partial[32] && diff[32];
        work_next  = borrow ? {work[62:0], 1'b0} : {diff[31:0], work[30:0], 1'b1};
        cap_signed = (op == DIV_OP) || (op == REM_OP);
        cap_rem    = (op == REM_OP) || (op == REMU_OP);
        q_fix      = (cap_signed && (sign_a ^ sign_b)) ? (32'h0 - work_next[31:0])
                                                       : work_next[31:0];
        r_fix      = (cap_signed && sign_a) ? (32'h0 - work_next[63:32]) : work_next[63:32];
        result     = cap_rem ? r_fix : q_fix;
    end

    // Next-state logic; flush overrides every state
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = zero_div ? DONE : BUSY;
                end else begin
                    state_next = IDLE;
                end
            end
            BUSY: begin
                if (cnt == 5'd31) begin
                    state_next = DONE;
                end else begin
                    state_next = BUSY;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end else begin
            state_next = state_next;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand capture, iteration datapath and registered results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op        <= 8'h0;
            wd_cap    <= 5'h0;
            wreg_cap  <= 1'b0;
            divisor   <= 32'h0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            work      <= 64'h0;
            cnt       <= 5'd0;
            div_done  <= 1'b0;
            div_wreg  <= 1'b0;
            div_wdata <= 32'h0;
            div_wd    <= 5'h0;
        end else begin
            div_done <= 1'b0;
            div_wreg <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op       <= ex_aluop;
                        wd_cap   <= ex_wd;
                        wreg_cap <= ex_wreg;
                        divisor  <= b_abs;
                        sign_a   <= ex_reg1[31];
                        sign_b   <= ex_reg2[31];
                        work     <= {32'h0, a_abs};
                        cnt      <= 5'd0;
                        if (zero_div) begin
                            div_done  <= 1'b1;
                            div_wreg  <= ex_wreg;
                            div_wd    <= ex_wd;
                            div_wdata <= in_rem ? ex_reg1 : 32'hFFFF_FFFF;
                        end
                    end
                end
                BUSY: begin
                    if (!flush) begin
                        work <= work_next;
                        cnt  <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            div_done  <= 1'b1;
                            div_wreg  <= wreg_cap;
                            div_wd    <= wd_cap;
                            div_wdata <= result;
                        end
                    end
                end
                default: begin
                    cnt <= cnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed corner cases plus randomized operations
// compared against an arithmetic reference model, with flush and async reset scenarios.
module tb_ex_div;

    localparam logic [7:0] DIV_OP  = 8'h60;
    localparam logic [7:0] DIVU_OP = 8'h61;
    localparam logic [7:0] REM_OP  = 8'h62;
    localparam logic [7:0] REMU_OP = 8'h63;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ex_aluop;
    logic [31:0] ex_reg1;
    logic [31:0] ex_reg2;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic        flush;
    logic        stallreq;
    logic        div_done;
    logic [31:0] div_wdata;
    logic [4:0]  div_wd;
    logic        div_wreg;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_wdata;

    ex_div dut (
        .clk       (clk),
        .rst       (rst),
        .ex_aluop  (ex_aluop),
        .ex_reg1   (ex_reg1),
        .ex_reg2   (ex_reg2),
        .ex_wd     (ex_wd),
        .ex_wreg   (ex_wreg),
        .flush     (flush),
        .stallreq  (stallreq),
        .div_done  (div_done),
        .div_wdata (div_wdata),
        .div_wd    (div_wd),
        .div_wreg  (div_wreg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic, truncating signed division, divide-by-zero rules
    function automatic logic [31:0] model(input logic [7:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'h0) begin
            return (op == REM_OP || op == REMU_OP) ? a : 32'hFFFF_FFFF;
        end
        case (op)
            DIV_OP:  t = sa / sb;
            DIVU_OP: t = {32'h0, a / b};
            REM_OP:  t = sa % sb;
            default: t = {32'h0, a % b};
        endcase
        return t[31:0];
    endfunction

    // Issues one op at cycle 0, then watches 40 cycles; flush_at>0 annuls it in that cycle
    task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic [4:0] wd, input logic wreg, input int flush_at);
        int          done_cyc = -1;
        int          done_cnt = 0;
        int          stall_cnt = 0;
        int          stray_wreg = 0;
        int          hold_err = 0;
        int          exp_lat;
        logic [31:0] held;
        logic [31:0] got_data = 32'h0;
        logic [4:0]  got_wd = 5'h0;
        logic        got_wreg = 1'b0;
        exp_lat = (b == 32'h0) ? 1 : 33;
        held    = last_wdata;
        @(negedge clk);
        ex_aluop = op; ex_reg1 = a; ex_reg2 = b; ex_wd = wd; ex_wreg = wreg; flush = 1'b0;
        #1;
        check({tag, " stall_c0"}, {31'h0, stallreq}, 32'h1);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            ex_aluop = 8'h00; ex_reg1 = $urandom; ex_reg2 = $urandom;
            ex_wd = 5'($urandom); ex_wreg = 1'($urandom); flush = (c == flush_at);
            #1;
            if (stallreq) stall_cnt++;
            if (div_done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c; got_data = div_wdata; got_wd = div_wd; got_wreg = div_wreg;
                    held = exp_res;
                end
            end else begin
                if (div_wreg) stray_wreg++;
                if (div_wdata !== held) hold_err++;
            end
            if (flush_at > 0 && c == flush_at + 1)
                check({tag, " stall_after_flush"}, {31'h0, stallreq}, 32'h0);
        end
        flush = 1'b0;
        check({tag, " hold"}, hold_err, 32'h0);
        check({tag, " stray_wreg"}, stray_wreg, 32'h0);
        if (flush_at > 0) begin
            check({tag, " done_count"}, done_cnt, 32'h0);
        end else begin
            check({tag, " done_cycle"}, done_cyc, exp_lat);
            check({tag, " done_count"}, done_cnt, 32'h1);
            check({tag, " stall_cycles"}, stall_cnt, exp_lat - 1);
            check({tag, " wdata"}, got_data, exp_res);
            check({tag, " wd"}, {27'h0, got_wd}, {27'h0, wd});
            check({tag, " wreg"}, {31'h0, got_wreg}, {31'h0, wreg});
            last_wdata = exp_res;
        end
    endtask

    initial begin
        logic [7:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        rst = 1'b1; ex_aluop = 8'h00; ex_reg1 = 32'h0; ex_reg2 = 32'h0;
        ex_wd = 5'h0; ex_wreg = 1'b0; flush = 1'b0; last_wdata = 32'h0;
        #2;
        check("reset done", {31'h0, div_done}, 32'h0);
        check("reset wreg", {31'h0, div_wreg}, 32'h0);
        check("reset wdata", div_wdata, 32'h0);
        check("reset wd", {27'h0, div_wd}, 32'h0);
        ex_aluop = DIV_OP; ex_reg1 = 32'd10; ex_reg2 = 32'd3;
        #1;
        check("reset stall", {31'h0, stallreq}, 32'h0);
        ex_aluop = 8'h00;
        #14 rst = 1'b0;

        run_op("divu_100_7", DIVU_OP, 32'd100, 32'd7, 32'd14, 5'd3, 1'b1, 0);
        run_op("remu_100_7", REMU_OP, 32'd100, 32'd7, 32'd2, 5'd4, 1'b1, 0);
        run_op("div_m7_2", DIV_OP, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 5'd5, 1'b1, 0);
        run_op("rem_m7_2", REM_OP, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 5'd6, 1'b1, 0);
        run_op("div_7_m2", DIV_OP, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 5'd7, 1'b0, 0);
        run_op("div_5_0", DIV_OP, 32'd5, 32'd0, 32'hFFFF_FFFF, 5'd8, 1'b1, 0);
        run_op("remu_5_0", REMU_OP, 32'd5, 32'd0, 32'd5, 5'd9, 1'b1, 0);
        run_op("div_ovf", DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 5'd10, 1'b1, 0);
        run_op("rem_ovf", REM_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 5'd11, 1'b1, 0);

        // Non-divide op and flushed divide op in IDLE must not start anything
        @(negedge clk); ex_aluop = 8'h20; #1;
        check("nondiv stall", {31'h0, stallreq}, 32'h0);
        @(negedge clk); ex_aluop = DIVU_OP; ex_reg2 = 32'd3; flush = 1'b1; #1;
        check("nondiv done", {31'h0, div_done}, 32'h0);
        check("idle_flush stall", {31'h0, stallreq}, 32'h0);
        @(negedge clk); ex_aluop = 8'h00; flush = 1'b0; #1;
        check("idle_flush done", {31'h0, div_done}, 32'h0);
        check("idle_flush state", {31'h0, stallreq}, 32'h0);

        run_op("flush_busy", DIVU_OP, 32'hDEAD_BEEF, 32'd13, 32'h0, 5'd12, 1'b1, 10);
        run_op("divu_9_3", DIVU_OP, 32'd9, 32'd3, 32'd3, 5'd13, 1'b1, 0);

        for (int i = 0; i < 24; i++) begin
            rop = 8'h60 + 8'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1:       rb = 32'($urandom_range(1, 20));
                2:       rb = 32'hFFFF_FFFF;
                3:       rb = 32'h8000_0000 | $urandom;
                default: rb = $urandom >> $urandom_range(0, 28);
            endcase
            run_op($sformatf("rand%0d", i), rop, ra, rb, model(rop, ra, rb),
                   5'($urandom), 1'($urandom), 0);
        end

        // Asynchronous reset mid-BUSY, released off the clock edge
        @(negedge clk); ex_aluop = DIV_OP; ex_reg1 = 32'h1234_5678; ex_reg2 = 32'd7;
        ex_wd = 5'd21; ex_wreg = 1'b1;
        @(negedge clk); ex_aluop = 8'h00;
        repeat (12) @(negedge clk);
        @(posedge clk); #3 rst = 1'b1; #1;
        check("arst done", {31'h0, div_done}, 32'h0);
        check("arst wreg", {31'h0, div_wreg}, 32'h0);
        check("arst wdata", div_wdata, 32'h0);
        check("arst wd", {27'h0, div_wd}, 32'h0);
        check("arst stall", {31'h0, stallreq}, 32'h0);
        last_wdata = 32'h0;
        #13 rst = 1'b0;
        run_op("after_rst", DIVU_OP, 32'd1000, 32'd10, 32'd100, 5'd19, 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got %0d expected finish", checks);
        $fatal(1, "timeout");
    end

endmodule
